// File: rtl/mem_access_ctrl_pkg.sv
// Shared aluop codes, FSM encodings and constants for the MEM-stage data-bus controller.
package mem_access_ctrl_pkg;

  localparam int ALUOP_W = 8;
  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t ALUOP_NOP = 8'h00;
  localparam aluop_t ALUOP_LB  = 8'h90;
  localparam aluop_t ALUOP_LBU = 8'h91;
  localparam aluop_t ALUOP_LH  = 8'h92;
  localparam aluop_t ALUOP_LHU = 8'h93;
  localparam aluop_t ALUOP_LW  = 8'h94;
  localparam aluop_t ALUOP_SB  = 8'h98;
  localparam aluop_t ALUOP_SH  = 8'h99;
  localparam aluop_t ALUOP_SW  = 8'h9A;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0]  WE_NONE    = 4'b0000;
  localparam logic [3:0]  WE_ALL     = 4'b1111;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b0;

  function automatic logic is_load(input aluop_t op);
    return (op == ALUOP_LB) || (op == ALUOP_LBU) || (op == ALUOP_LH) ||
           (op == ALUOP_LHU) || (op == ALUOP_LW);
  endfunction

  function automatic logic is_store(input aluop_t op);
    return (op == ALUOP_SB) || (op == ALUOP_SH) || (op == ALUOP_SW);
  endfunction

  // Half ops need an even address, word ops a 4-byte aligned one.
  function automatic logic is_misaligned(input aluop_t op, input logic [1:0] a);
    logic half_op;
    logic word_op;
    half_op = (op == ALUOP_LH) || (op == ALUOP_LHU) || (op == ALUOP_SH);
    word_op = (op == ALUOP_LW) || (op == ALUOP_SW);
    return (half_op && a[0]) || (word_op && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-bus request/ack channel between the MEM stage and the data memory.
interface mem_access_ctrl_if;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  dwe;
  logic [31:0] dwdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (output dce, daddr, dwe, dwdata, input dm_rdata, dm_ack);
  modport slave  (input dce, daddr, dwe, dwdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_access_ctrl_lane_fmt.sv
// Combinational byte-lane steering: store enables/replicated data and load extraction/extension.
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] din,
  input  logic [31:0] rdata,
  output logic [3:0]  we,
  output logic [31:0] wdata,
  output logic [31:0] ld_fmt
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    we    = WE_NONE;
    wdata = ZERO_WORD;
    case (aluop)
      ALUOP_SB: begin
        we    = 4'b0001 << addr_lo;
        wdata = {4{din[7:0]}};
      end
      ALUOP_SH: begin
        we    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din[15:0]}};
      end
      ALUOP_SW: begin
        we    = WE_ALL;
        wdata = din;
      end
      default: ;
    endcase
  end

  always_comb begin
    rbyte  = rdata[{addr_lo, 3'b000} +: 8];
    rhalf  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ld_fmt = ZERO_WORD;
    case (aluop)
      ALUOP_LB:  ld_fmt = {{24{rbyte[7]}}, rbyte};
      ALUOP_LBU: ld_fmt = {24'h000000, rbyte};
      ALUOP_LH:  ld_fmt = {{16{rhalf[15]}}, rhalf};
      ALUOP_LHU: ld_fmt = {16'h0000, rhalf};
      ALUOP_LW:  ld_fmt = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: IDLE->WAIT->DONE bus handshake with timeout, pipeline stall
// and registered load result; misaligned ops raise mem_adel/mem_ades without touching the bus.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst_n,
  input  aluop_t               mem_aluop,
  input  logic [31:0]          mem_wd,
  input  logic [31:0]          mem_din,
  input  logic                 mem_flush,
  mem_access_ctrl_if.master    bus,
  output logic                 stallreq_mem,
  output logic [31:0]          ld_data,
  output logic                 ld_valid,
  output logic                 mem_adel,
  output logic                 mem_ades,
  output logic                 bus_err
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  aluop_t           op_q;
  logic [31:0]      addr_q;
  logic [3:0]       dwe_q;
  logic [31:0]      dwdata_q;
  logic             discard_q;
  logic             err_q;

  aluop_t           op_cur;
  logic [1:0]       addr_lo_cur;
  logic [3:0]       fmt_we;
  logic [31:0]      fmt_wdata;
  logic [31:0]      fmt_ld;
  logic             is_mem;
  logic             mis;
  logic             req_go;
  logic             timeout;

  // In IDLE the formatter sees the live EXE/MEM op; afterwards it sees the captured one.
  assign op_cur      = (state == IDLE) ? mem_aluop : op_q;
  assign addr_lo_cur = (state == IDLE) ? mem_wd[1:0] : addr_q[1:0];

  mem_lane_fmt u_lane_fmt (
    .aluop   (op_cur),
    .addr_lo (addr_lo_cur),
    .din     (mem_din),
    .rdata   (bus.dm_rdata),
    .we      (fmt_we),
    .wdata   (fmt_wdata),
    .ld_fmt  (fmt_ld)
  );

  assign is_mem  = is_load(mem_aluop) || is_store(mem_aluop);
  assign mis     = is_misaligned(mem_aluop, mem_wd[1:0]);
  // Gating with the reset keeps the bus quiet while reset is held, even with a memory op pending.
  assign req_go  = cpu_rst_n && is_mem && !mis && !mem_flush;
  assign cnt_nxt = cnt + 1'b1;
  assign timeout = (cnt_nxt == TMO);

  always_comb begin
    bus.dce      = 1'b0;
    bus.daddr    = ZERO_WORD;
    bus.dwe      = WE_NONE;
    bus.dwdata   = ZERO_WORD;
    stallreq_mem = 1'b0;
    case (state)
      IDLE: if (req_go) begin
        bus.dce      = 1'b1;
        bus.daddr    = {mem_wd[31:2], 2'b00};
        bus.dwe      = fmt_we;
        bus.dwdata   = fmt_wdata;
        stallreq_mem = 1'b1;
      end
      WAIT: begin
        bus.dce      = 1'b1;
        bus.daddr    = {addr_q[31:2], 2'b00};
        bus.dwe      = dwe_q;
        bus.dwdata   = dwdata_q;
        stallreq_mem = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_adel = (state == IDLE) && is_load(mem_aluop) && mis;
  assign mem_ades = (state == IDLE) && is_store(mem_aluop) && mis;
  assign ld_valid = (state == DONE) && is_load(op_q) && !discard_q;
  assign bus_err  = (state == DONE) && err_q && !discard_q;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= ALUOP_NOP;
      addr_q    <= ZERO_WORD;
      dwe_q     <= WE_NONE;
      dwdata_q  <= ZERO_WORD;
      ld_data   <= ZERO_WORD;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_go) begin
          state     <= WAIT;
          cnt       <= '0;
          op_q      <= mem_aluop;
          addr_q    <= mem_wd;
          dwe_q     <= fmt_we;
          dwdata_q  <= fmt_wdata;
          discard_q <= 1'b0;
          err_q     <= 1'b0;
        end
        WAIT: begin
          cnt <= cnt_nxt;
          // A flush cannot abort the bus cycle; it only hides the result in DONE.
          if (mem_flush) discard_q <= 1'b1;
          if (bus.dm_ack) begin
            if (is_load(op_q)) ld_data <= fmt_ld;
            state <= DONE;
          end else if (timeout) begin
            ld_data <= ZERO_WORD;
            err_q   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed cases then randomized load/store traffic.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TMO = 6;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n   = 1'b0;
  aluop_t      mem_aluop;
  logic [31:0] mem_wd, mem_din;
  logic        mem_flush;
  logic        stallreq_mem, ld_valid, mem_adel, mem_ades, bus_err;
  logic [31:0] ld_data;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst_n    (cpu_rst_n),
    .mem_aluop    (mem_aluop),
    .mem_wd       (mem_wd),
    .mem_din      (mem_din),
    .mem_flush    (mem_flush),
    .bus          (bus),
    .stallreq_mem (stallreq_mem),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .mem_adel     (mem_adel),
    .mem_ades     (mem_ades),
    .bus_err      (bus_err)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; } req_exp_t;
  typedef struct { logic chk_data; logic [31:0] data; logic valid; logic err; int stall; } done_exp_t;
  typedef struct { logic adel; logic ades; } exc_exp_t;

  req_exp_t  req_q[$];
  done_exp_t done_q[$];
  exc_exp_t  exc_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain shifts/masks/arithmetic on byte lanes.
  function automatic logic [31:0] ref_load(input aluop_t op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> ((a % 4) * 8)) & 32'hFF;
    h = (rd >> (((a / 2) % 2) * 16)) & 32'hFFFF;
    case (op)
      ALUOP_LB:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      ALUOP_LBU: return b;
      ALUOP_LH:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      ALUOP_LHU: return h;
      default:   return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_we(input aluop_t op, input logic [31:0] a);
    logic [31:0] w;
    case (op)
      ALUOP_SB: w = 32'd1 << (a % 4);
      ALUOP_SH: w = 32'd3 << (2 * ((a / 2) % 2));
      ALUOP_SW: w = 32'd15;
      default:  w = 32'd0;
    endcase
    return w[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input aluop_t op, input logic [31:0] din);
    case (op)
      ALUOP_SB: return (din & 32'hFF) * 32'h0101_0101;
      ALUOP_SH: return (din & 32'hFFFF) * 32'h0001_0001;
      ALUOP_SW: return din;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic bit ref_is_load(input aluop_t op);
    return op inside {ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW};
  endfunction

  function automatic bit ref_is_store(input aluop_t op);
    return op inside {ALUOP_SB, ALUOP_SH, ALUOP_SW};
  endfunction

  function automatic bit ref_mis(input aluop_t op, input logic [31:0] a);
    if (op inside {ALUOP_LH, ALUOP_LHU, ALUOP_SH}) return (a % 2) != 0;
    if (op inside {ALUOP_LW, ALUOP_SW}) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Starts and ends at posedge+1. ack_at: WAIT cycle of dm_ack (0 or >TMO = never);
  // flush_at: WAIT cycle of mem_flush (waits+1 = during DONE); flush_idle: flush in IDLE.
  task automatic do_op(input aluop_t op, input logic [31:0] a, input logic [31:0] din,
                       input logic [31:0] rd, input int ack_at, input int flush_at, input bit flush_idle);
    bit ld, st, timed, flushed;
    int waits;
    req_exp_t r;
    done_exp_t d;
    exc_exp_t e;
    ld = ref_is_load(op);
    st = ref_is_store(op);
    mem_aluop = op; mem_wd = a; mem_din = din; mem_flush = flush_idle;
    if (!(ld || st) || ref_mis(op, a) || flush_idle) begin
      if (ref_mis(op, a)) begin
        e.adel = ld; e.ades = st;
        exc_q.push_back(e);
      end
      @(posedge cpu_clk_50M); #1;
      mem_aluop = ALUOP_NOP; mem_flush = 1'b0;
      return;
    end
    timed   = !(ack_at >= 1 && ack_at <= TMO);
    waits   = timed ? TMO : ack_at;
    flushed = (flush_at >= 1 && flush_at <= waits);
    r.addr = a & 32'hFFFF_FFFC; r.we = ref_we(op, a); r.wdata = ref_wdata(op, din);
    req_q.push_back(r);
    d.chk_data = ld && !flushed;
    d.data     = timed ? 32'h0 : ref_load(op, a, rd);
    d.valid    = ld && !flushed;
    d.err      = timed && !flushed;
    d.stall    = 1 + waits;
    done_q.push_back(d);
    @(posedge cpu_clk_50M); #1;
    for (int k = 1; k <= waits; k++) begin
      bus.dm_ack = (k == ack_at);
      bus.dm_rdata = rd;
      mem_flush = (k == flush_at);
      @(posedge cpu_clk_50M); #1;
    end
    bus.dm_ack = 1'b0;
    mem_flush = (flush_at == waits + 1);
    @(posedge cpu_clk_50M); #1;
    mem_aluop = ALUOP_NOP; mem_flush = 1'b0;
  endtask

  initial begin : monitor
    bit prev_stall;
    int stall_cnt;
    req_exp_t r;
    done_exp_t d;
    exc_exp_t e;
    prev_stall = 1'b0;
    stall_cnt = 0;
    forever begin
      @(negedge cpu_clk_50M);
      if (!cpu_rst_n) begin
        prev_stall = 1'b0;
        stall_cnt = 0;
      end else begin
        if (bus.dce) begin
          if (req_q.size() == 0) check("dce_without_request", 32'(bus.dce), 32'h0);
          else begin
            r = req_q[0];
            check("daddr", bus.daddr, r.addr);
            check("dwe", 32'(bus.dwe), 32'(r.we));
            check("dwdata", bus.dwdata, r.wdata);
          end
        end
        if (mem_adel || mem_ades) begin
          if (exc_q.size() == 0) check("exc_without_op", {30'h0, mem_adel, mem_ades}, 32'h0);
          else begin
            e = exc_q.pop_front();
            check("mem_adel", 32'(mem_adel), 32'(e.adel));
            check("mem_ades", 32'(mem_ades), 32'(e.ades));
            check("mis_dce", 32'(bus.dce), 32'h0);
            check("mis_stall", 32'(stallreq_mem), 32'h0);
          end
        end
        if (stallreq_mem) stall_cnt++;
        if (prev_stall && !stallreq_mem) begin
          if (done_q.size() == 0) check("done_without_op", 32'(prev_stall), 32'h0);
          else begin
            d = done_q.pop_front();
            if (req_q.size() != 0) void'(req_q.pop_front());
            check("ld_valid", 32'(ld_valid), 32'(d.valid));
            check("bus_err", 32'(bus_err), 32'(d.err));
            check("done_dce", 32'(bus.dce), 32'h0);
            check("stall_cycles", stall_cnt, d.stall);
            if (d.chk_data) check("ld_data", ld_data, d.data);
          end
          stall_cnt = 0;
        end else if (ld_valid || bus_err) begin
          check("stray_pulse", {30'h0, ld_valid, bus_err}, 32'h0);
        end
        prev_stall = stallreq_mem;
      end
    end
  end

  initial begin : stim
    aluop_t ops[9];
    req_exp_t r;
    aluop_t op;
    logic [31:0] a;
    int ack_at, flush_at;
    bit fidle;
    ops = '{ALUOP_NOP, ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW, ALUOP_SB, ALUOP_SH, ALUOP_SW};
    mem_aluop = ALUOP_NOP; mem_wd = '0; mem_din = '0; mem_flush = 1'b0;
    bus.dm_ack = 1'b0; bus.dm_rdata = '0;
    #15;
    check("rst_dce", 32'(bus.dce), 32'h0);
    check("rst_dwe", 32'(bus.dwe), 32'h0);
    check("rst_daddr", bus.daddr, 32'h0);
    check("rst_dwdata", bus.dwdata, 32'h0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_ld_valid", 32'(ld_valid), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_stall", 32'(stallreq_mem), 32'h0);
    @(posedge cpu_clk_50M); #1;
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M); #1;

    do_op(ALUOP_LW,  32'h100, 32'h0,  32'hDEAD_BEEF, 1, 0, 0);
    do_op(ALUOP_LB,  32'h103, 32'h0,  32'h8011_2233, 2, 0, 0);
    do_op(ALUOP_LBU, 32'h103, 32'h0,  32'h8011_2233, 1, 0, 0);
    do_op(ALUOP_LH,  32'h102, 32'h0,  32'h8011_2233, 3, 0, 0);
    do_op(ALUOP_LHU, 32'h102, 32'h0,  32'h8011_2233, 1, 0, 0);
    do_op(ALUOP_SB,  32'h201, 32'hAB, 32'h0,         5, 0, 0);
    do_op(ALUOP_LW,  32'h102, 32'h0,  32'h0,         1, 0, 0);
    do_op(ALUOP_SH,  32'h105, 32'h1234, 32'h0,       1, 0, 0);
    do_op(ALUOP_LW,  32'h300, 32'h0,  32'h1234_5678, 0, 0, 0);
    do_op(ALUOP_LW,  32'h304, 32'h0,  32'h1111_2222, TMO, 0, 0);
    do_op(ALUOP_LW,  32'h308, 32'h0,  32'h5555_AAAA, 2, 1, 0);
    do_op(ALUOP_LHU, 32'h30A, 32'h0,  32'h5555_AAAA, 2, 3, 0);
    do_op(ALUOP_SW,  32'h400, 32'h55, 32'h0,         1, 0, 1);
    do_op(ALUOP_NOP, 32'h500, 32'h0,  32'h0,         1, 0, 0);

    // Reset in the middle of WAIT must drop the bus request and stall at once.
    mem_aluop = ALUOP_LW; mem_wd = 32'h40;
    r.addr = 32'h40; r.we = 4'h0; r.wdata = 32'h0;
    req_q.push_back(r);
    @(posedge cpu_clk_50M); #1;
    @(posedge cpu_clk_50M); #1;
    cpu_rst_n = 1'b0;
    #1;
    check("arst_dce", 32'(bus.dce), 32'h0);
    check("arst_stall", 32'(stallreq_mem), 32'h0);
    req_q.delete();
    @(posedge cpu_clk_50M); #1;
    mem_aluop = ALUOP_NOP;
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M); #1;
    do_op(ALUOP_LW, 32'h44, 32'h0, 32'hCAFE_F00D, 1, 0, 0);

    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 8)];
      a  = {20'h0, 10'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      else if (op inside {ALUOP_LB, ALUOP_LBU, ALUOP_SB}) a[1:0] = 2'($urandom);
      else if (op inside {ALUOP_LH, ALUOP_LHU, ALUOP_SH}) a[1] = 1'($urandom);
      ack_at   = $urandom_range(1, TMO + 1);
      flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO + 1) : 0;
      fidle    = ($urandom_range(0, 9) == 0);
      do_op(op, a, $urandom, $urandom, ack_at, flush_at, fidle);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge cpu_clk_50M); #1;
      end
    end

    repeat (3) @(posedge cpu_clk_50M);
    #1;
    check("req_q_left", req_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
    check("exc_q_left", exc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
